song_sequencer: RTL and testbench

- Playback controller for the music-box datapath.
- Generates the note ROM address, paces note duration from the 100 Hz tick and gates the tone divider output.
- Executes play/pause/next/prev/stop commands from the IR decoder.
- Sits between CLK100H/IR and the ROM → ToneDecode → DCD chain, replacing free-running address generation.

---
 rtl/song_sequencer.sv | 136 +++++++++++++
 tb/tb_song_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Music-box playback controller: walks note ROM addresses, paces notes from the 100 Hz tick,
// and gates the tone output. Optional macro REPEAT_ONE_EN makes end-of-song replay the same song.
module song_sequencer #(
    parameter int SONG_W     = 2,
    parameter int OFF_W      = 5,
    parameter int NOTE_TICKS = 25,
    parameter int END_CODE   = 15,
    parameter int REST_CODE  = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    tick,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd,
    input  logic [3:0]              rom_index,
    output logic [SONG_W+OFF_W-1:0] rom_addr,
    output logic [SONG_W-1:0]       song_sel,
    output logic [1:0]              state,
    output logic                    tone_en,
    output logic                    song_done
);

    localparam int CNT_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [3:0] END_IDX  = 4'(END_CODE);
    localparam logic [3:0] REST_IDX = 4'(REST_CODE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tone_en_q, tone_en_d;
    logic                song_done_q, song_done_d;
    logic                eos;

    // Handshake: cmd is sampled only in a cycle where cmd_valid is high; there is no ready,
    // every strobe is consumed in its own cycle and outranks end-of-song and tick.
    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        song_done_d = 1'b0;
        eos         = 1'b0;
        tone_en_d   = (state_q == ST_PLAY) && (rom_index != REST_IDX) && (rom_index != END_IDX);

        if (cmd_valid) begin
            unique case (cmd)
                2'b00: begin
                    unique case (state_q)
                        ST_IDLE: begin
                            state_d = ST_PLAY;
                            cnt_d   = '0;
                        end
                        ST_PLAY:  state_d = ST_PAUSE;
                        ST_PAUSE: state_d = ST_PLAY;
                        default:  state_d = ST_IDLE;
                    endcase
                end
                2'b01: begin
                    song_d   = song_q + SONG_W'(1);
                    offset_d = '0;
                    cnt_d    = '0;
                end
                2'b10: begin
                    song_d   = song_q - SONG_W'(1);
                    offset_d = '0;
                    cnt_d    = '0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    offset_d = '0;
                    cnt_d    = '0;
                end
            endcase
        end else if (state_q == ST_PLAY) begin
            if (rom_index == END_IDX) begin
                eos = 1'b1;
            end else if (tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Running off the end of the song window counts as end-of-song.
                    if (offset_q == '1) begin
                        eos = 1'b1;
                    end else begin
                        offset_d = offset_q + OFF_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        if (eos) begin
`ifdef REPEAT_ONE_EN
            song_d = song_q;
`else
            song_d = song_q + SONG_W'(1);
`endif
            offset_d    = '0;
            cnt_d       = '0;
            song_done_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            song_q      <= '0;
            offset_q    <= '0;
            cnt_q       <= '0;
            tone_en_q   <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            tone_en_q   <= tone_en_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr  = {song_q, offset_q};
    assign song_sel  = song_q;
    assign state     = state_q;
    assign tone_en   = tone_en_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random commands/ticks against a
// behavioural playback model; a behavioural ROM answers rom_addr.
module tb_song_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [3:0] rom_index;
    logic [6:0] rom_addr;
    logic [1:0] song_sel;
    logic [1:0] state;
    logic       tone_en;
    logic       song_done;

    logic [3:0] rom_mem [0:127];

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard: {rom_addr, song_sel, state, tone_en, song_done} expected after each edge.
    logic [12:0] exp_q[$];

    // Model: state 0 idle, 1 play, 2 pause.
    int   m_state, m_song, m_off, m_cnt;
    logic m_tone, m_done;

    song_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .rom_index (rom_index),
        .rom_addr  (rom_addr),
        .song_sel  (song_sel),
        .state     (state),
        .tone_en   (tone_en),
        .song_done (song_done)
    );

    always #5 CLK = ~CLK;

    assign rom_index = rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_song  = 0;
        m_off   = 0;
        m_cnt   = 0;
        m_tone  = 1'b0;
        m_done  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic t, input logic v, input logic [1:0] c);
        int  idx;
        bit  eos;
        idx  = int'(rom_mem[m_song * 32 + m_off]);
        eos  = 1'b0;
        m_tone = (m_state == 1) && (idx != 0) && (idx != 15);
        m_done = 1'b0;
        if (v) begin
            case (c)
                2'd0: begin
                    if (m_state == 0) begin
                        m_state = 1;
                        m_cnt   = 0;
                    end else if (m_state == 1) begin
                        m_state = 2;
                    end else begin
                        m_state = 1;
                    end
                end
                2'd1: begin
                    m_song = (m_song + 1) % 4;
                    m_off  = 0;
                    m_cnt  = 0;
                end
                2'd2: begin
                    m_song = (m_song + 3) % 4;
                    m_off  = 0;
                    m_cnt  = 0;
                end
                default: begin
                    m_state = 0;
                    m_off   = 0;
                    m_cnt   = 0;
                end
            endcase
        end else if (m_state == 1) begin
            if (idx == 15) begin
                eos = 1'b1;
            end else if (t) begin
                if (m_cnt == 24) begin
                    m_cnt = 0;
                    if (m_off == 31) eos = 1'b1;
                    else m_off = m_off + 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        if (eos) begin
`ifndef REPEAT_ONE_EN
            m_song = (m_song + 1) % 4;
`endif
            m_off  = 0;
            m_cnt  = 0;
            m_done = 1'b1;
        end
        exp_q.push_back({2'(m_song), 5'(m_off), 2'(m_song), 2'(m_state), m_tone, m_done});
    endtask

    task automatic check_outputs();
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            chk("cycle", 16'({rom_addr, song_sel, state, tone_en, song_done}), 16'(e));
        end
    endtask

    // One clock: drive inputs, predict, check 1 ns after the edge.
    task automatic cycle(input logic t, input logic v, input logic [1:0] c);
        tick      = t;
        cmd_valid = v;
        cmd       = c;
        model_step(t, v, c);
        @(posedge CLK);
        #1;
        check_outputs();
        tick      = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 2'b00);
            cycle(1'b0, 1'b0, 2'b00);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        #1 RST = 1'b1;
        #1;
        chk("async_reset", 16'({rom_addr, song_sel, state, tone_en, song_done}), 16'h0);
        model_reset();
        RST = 1'b0;
        #1;
    endtask

    task automatic fill_song(input int s);
        for (int i = 0; i < 32; i++) rom_mem[s * 32 + i] = 4'($urandom_range(1, 14));
    endtask

    initial begin
        for (int s = 0; s < 4; s++) fill_song(s);
        rom_mem[0]  = 4'd5;
        rom_mem[1]  = 4'd7;
        rom_mem[3]  = 4'd9;
        rom_mem[32] = 4'd0;
        rom_mem[102] = 4'd15;

        // Power-on reset
        #1 RST = 1'b1;
        #2;
        chk("reset_async", 16'({rom_addr, song_sel, state, tone_en, song_done}), 16'h0);
        @(posedge CLK);
        #2;
        chk("reset_held", 16'({rom_addr, song_sel, state, tone_en, song_done}), 16'h0);
        model_reset();
        RST = 1'b0;

        // Play from IDLE, note pacing
        cycle(1'b0, 1'b1, 2'b00);
        chk("play_state", 16'(state), 16'd1);
        cycle(1'b0, 1'b0, 2'b00);
        chk("play_tone_en", 16'(tone_en), 16'd1);
        ticks(25);
        chk("addr_after_25", 16'(rom_addr), 16'd1);
        ticks(25);
        chk("addr_after_50", 16'(rom_addr), 16'd2);

        // Pause at counter 10, resume from frozen counter
        ticks(10);
        cycle(1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 2'b00);
        chk("pause_state", 16'(state), 16'd2);
        chk("pause_tone_en", 16'(tone_en), 16'd0);
        ticks(40);
        chk("pause_addr_held", 16'(rom_addr), 16'd2);
        cycle(1'b0, 1'b1, 2'b00);
        ticks(14);
        chk("resume_14", 16'(rom_addr), 16'd2);
        ticks(1);
        chk("resume_15", 16'(rom_addr), 16'd3);

        // Reset mid-note
        ticks(7);
        chk("pre_reset_tone", 16'(tone_en), 16'd1);
        async_reset();

        // Song select commands
        cycle(1'b0, 1'b1, 2'b10);
        chk("prev_wrap", 16'({song_sel, rom_addr}), 16'({2'd3, 7'd96}));
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        chk("next_twice", 16'(song_sel), 16'd1);
        cycle(1'b0, 1'b1, 2'b11);
        chk("stop", 16'({song_sel, state}), 16'({2'd1, 2'd0}));

        // End code in song 3 at offset 6
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b00);
        ticks(149);
        cycle(1'b1, 1'b0, 2'b00);
        chk("reach_end_word", 16'({rom_addr, song_done}), 16'({7'd102, 1'b0}));
        cycle(1'b0, 1'b0, 2'b00);
`ifdef REPEAT_ONE_EN
        chk("eos_song", 16'({song_sel, rom_addr, song_done}), 16'({2'd3, 7'd96, 1'b1}));
`else
        chk("eos_song", 16'({song_sel, rom_addr, song_done}), 16'({2'd0, 7'd0, 1'b1}));
`endif
        cycle(1'b0, 1'b0, 2'b00);
        chk("eos_pulse_end", 16'({song_done, state}), 16'({1'b0, 2'd1}));

        // Command on the note-advance tick wins
        async_reset();
        cycle(1'b0, 1'b1, 2'b00);
        ticks(100);
        chk("at_offset4", 16'(rom_addr), 16'd4);
        ticks(24);
        cycle(1'b1, 1'b1, 2'b01);
        chk("cmd_beats_tick", 16'({song_sel, rom_addr, song_done}), 16'({2'd1, 7'd32, 1'b0}));
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b00);
        chk("rest_mutes", 16'({state, tone_en}), 16'({2'd1, 1'b0}));

        // Offset wrap on a song with no end code
        async_reset();
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b00);
        ticks(799);
        chk("before_wrap", 16'(rom_addr), 16'(7'd95));
        cycle(1'b1, 1'b0, 2'b00);
`ifdef REPEAT_ONE_EN
        chk("offset_wrap", 16'({rom_addr, song_done}), 16'({7'd64, 1'b1}));
`else
        chk("offset_wrap", 16'({rom_addr, song_done}), 16'({7'd96, 1'b1}));
`endif

        // Random ROM contents and random ticks/commands
        for (int i = 0; i < 128; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
